// File: rtl/party_btn_pkg.sv
// Shared definitions for the party-game button peripheral: register offsets and FIRST-register layout.
package party_btn_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_EDGE  = 2'd2;
  localparam logic [1:0] REG_FIRST = 2'd3;

  localparam int FIRST_VALID_BIT = 31;
  localparam int FIRST_IDX_W     = 8;

  typedef struct packed {
    logic                   valid;
    logic [FIRST_IDX_W-1:0] idx;
  } first_t;

  function automatic logic [31:0] first_word(input first_t f);
    logic [31:0] w;
    w                  = '0;
    w[FIRST_VALID_BIT] = f.valid;
    w[FIRST_IDX_W-1:0] = f.idx;
    return w;
  endfunction

endpackage

// File: rtl/party_button_pio_if.sv
// Avalon-MM slave bus bundle for the button peripheral (readLatency = 1).
interface party_button_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata);
endinterface

// File: rtl/party_button_pio_debounce.sv
// One button channel: 2-flop synchroniser, saturating debounce counter, one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic pad_i,
  output logic level_o,
  output logic press_o
);
  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, p_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (p_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = p_q;
        press_d  = p_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Polarity is folded in ahead of the synchroniser so cleared flops mean "released".
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q   <= 1'b0;
      p_q      <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      meta_q   <= pad_i ^ ACTIVE_LOW;
      p_q      <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;
endmodule

// File: rtl/party_button_pio.sv
// N-channel button PIO: debounced levels, sticky press flags, masked IRQ, Avalon-MM register file.
// Optional first-press arbiter built only when PARTY_BTN_FIRST_EN is defined.
module party_button_pio
  import party_btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_BTN-1:0] button_export,
  party_button_pio_if.slave  avs,
  output logic               irq
);
  logic [NUM_BTN-1:0] level, press;
  logic [NUM_BTN-1:0] mask_q, mask_d;
  logic [NUM_BTN-1:0] edge_q, edge_d;
  logic [31:0]        rdata_q, rdata_d, rd_word, first_rd;
  logic               irq_q, irq_d;
  logic               wr_mask, wr_edge, wr_first;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_deb (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pad_i         (button_export[g]),
      .level_o       (level[g]),
      .press_o       (press[g])
    );
  end

  assign wr_mask      = avs.avs_write && (avs.avs_address == REG_MASK);
  assign wr_edge      = avs.avs_write && (avs.avs_address == REG_EDGE);
  assign wr_first     = avs.avs_write && (avs.avs_address == REG_FIRST);
  assign unused_wdata = ^avs.avs_writedata;

`ifdef PARTY_BTN_FIRST_EN
  first_t first_q, first_d;

  // Clear applies first so a press in the clearing cycle is still latched.
  always_comb begin
    first_d = first_q;
    if (wr_first) first_d = '0;
    if (!first_d.valid && |press) begin
      first_d.valid = 1'b1;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
        if (press[i]) first_d.idx = FIRST_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) first_q <= '0;
    else                first_q <= first_d;
  end

  assign first_rd = first_word(first_q);
`else
  assign first_rd = '0;
`endif

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = avs.avs_writedata[NUM_BTN-1:0];

    edge_d = edge_q;
    if (wr_edge) edge_d = edge_q & ~avs.avs_writedata[NUM_BTN-1:0];
    edge_d = edge_d | press;

    irq_d = |(edge_q & mask_q);

    rd_word = '0;
    case (avs.avs_address)
      REG_DATA:  rd_word[NUM_BTN-1:0] = level;
      REG_MASK:  rd_word[NUM_BTN-1:0] = mask_q;
      REG_EDGE:  rd_word[NUM_BTN-1:0] = edge_q;
      REG_FIRST: rd_word              = first_rd;
      default:   rd_word              = '0;
    endcase

    rdata_d = avs.avs_read ? rd_word : rdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mask_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign irq              = irq_q;
endmodule

// File: tb/tb_party_button_pio.sv
// Directed bench for party_button_pio with a read-data scoreboard; FIRST expectations follow PARTY_BTN_FIRST_EN.
module tb_party_button_pio;
  import party_btn_pkg::*;

  localparam int NB = 4;
  localparam int DB = 8;

`ifdef PARTY_BTN_FIRST_EN
  localparam logic [31:0] FIRST_EXP = 32'h8000_0001;
`else
  localparam logic [31:0] FIRST_EXP = 32'h0000_0000;
`endif

  logic          clk_clk       = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic [NB-1:0] button_export = '1;
  logic          irq;

  party_button_pio_if bus ();

  party_button_pio #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .button_export (button_export),
    .avs           (bus.slave),
    .irq           (irq)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic sb_pop();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_underflow: observed=read with no expectation expected=queued entry");
    end else begin
      chk(bus.avs_readdata, exp_q.pop_front(), tag_q.pop_front());
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick(1);
    bus.avs_read    = 1'b0;
    sb_pop();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick(1);
    bus.avs_write     = 1'b0;
  endtask

  task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_read      = 1'b1;
    bus.avs_write     = 1'b1;
    tick(1);
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    sb_pop();
  endtask

  initial begin
    #100us;
    $fatal(1, "FAIL watchdog: observed=timeout expected=bench completion");
  end

  initial begin
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    tick(3);
    chk(bus.avs_readdata, 32'h0, "rst_rdata_in_reset");
    chk(32'(irq), 32'h0, "rst_irq_in_reset");
    reset_reset_n = 1'b1;
    tick(2);

    rd(REG_DATA,  32'h0, "rst_data");
    rd(REG_MASK,  32'h0, "rst_mask");
    rd(REG_EDGE,  32'h0, "rst_edge");
    rd(REG_FIRST, 32'h0, "rst_first");

    // Reset in the middle of a debounce count; pad released while in reset.
    button_export[0] = 1'b0;
    tick(7);
    reset_reset_n    = 1'b0;
    button_export[0] = 1'b1;
    tick(2);
    reset_reset_n    = 1'b1;
    tick(20);
    rd(REG_DATA, 32'h0, "t1_data");
    rd(REG_EDGE, 32'h0, "t1_edge");
    chk(32'(irq), 32'h0, "t1_irq");

    // Glitches of 5 and DB-1 cycles must not be accepted.
    button_export[1] = 1'b0;
    tick(5);
    button_export[1] = 1'b1;
    tick(20);
    rd(REG_DATA, 32'h0, "t2_data_g5");
    rd(REG_EDGE, 32'h0, "t2_edge_g5");
    button_export[1] = 1'b0;
    tick(DB - 1);
    button_export[1] = 1'b1;
    tick(20);
    rd(REG_DATA, 32'h0, "t2_data_g7");
    rd(REG_EDGE, 32'h0, "t2_edge_g7");

    // Clean press with IRQ enabled: irq rises exactly 2+DB+2 cycles after the pad edge.
    wr(REG_MASK, 32'h4);
    button_export[2] = 1'b0;
    tick(2 + DB + 1);
    chk(32'(irq), 32'h0, "t3_irq_early");
    tick(1);
    chk(32'(irq), 32'h1, "t3_irq_rise");
    rd(REG_DATA, 32'h4, "t3_data");
    rd(REG_EDGE, 32'h4, "t3_edge");
    tick(6);
    button_export[2] = 1'b1;
    tick(15);
    rd(REG_DATA, 32'h0, "t3_data_released");
    rd(REG_EDGE, 32'h4, "t3_edge_sticky");
    wr(REG_EDGE, 32'h4);
    chk(32'(irq), 32'h1, "t3_irq_registered");
    tick(1);
    chk(32'(irq), 32'h0, "t3_irq_cleared");
    rd(REG_EDGE, 32'h0, "t3_edge_cleared");

    // Press pulse lands in the same cycle as a W1C of that bit.
    button_export[3] = 1'b0;
    tick(2 + DB);
    wr(REG_EDGE, 32'h8);
    rd(REG_EDGE, 32'h8, "t4_set_wins");
    chk(32'(irq), 32'h0, "t4_irq_masked");
    button_export[3] = 1'b1;
    tick(15);
    wr(REG_EDGE, 32'hF);
    rd(REG_EDGE, 32'h0, "t4_edge_clear_all");

    rw(REG_MASK, 32'hFFFF_FFFF, 32'h4, "rw_pre_write_value");
    rd(REG_MASK, 32'hF, "mask_upper_bits_zero");
    wr(REG_DATA, 32'hF);
    rd(REG_DATA, 32'h0, "data_write_ignored");
    wr(REG_MASK, 32'h0);

    // First-press arbitration: simultaneous presses on channels 1 and 3.
    button_export = 4'b0101;
    tick(15);
    rd(REG_EDGE,  32'hA, "t5_edge_both");
    rd(REG_FIRST, FIRST_EXP, "t5_first_lowest");
    button_export = 4'b1111;
    tick(15);
    button_export[0] = 1'b0;
    tick(15);
    rd(REG_FIRST, FIRST_EXP, "t5_first_held");
    button_export[0] = 1'b1;
    tick(15);
    wr(REG_FIRST, 32'h0);
    rd(REG_FIRST, 32'h0, "t5_first_cleared");

    chk(32'(exp_q.size()), 32'h0, "sb_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
